mod_sequencer: RTL and testbench

Multi-cycle controller that computes an unsigned remainder, dividend mod divisor, by repeated subtraction. It borrows the shared 32-bit combinational ALU and drives its operand and control inputs each cycle. It also counts the quotient and reports completion with a one-cycle `done` pulse. It sits beside the ALU in the execute stage and supplies the result for the ALU's otherwise unused mod opcode (3'b111).

---
 rtl/mod_sequencer_if.sv | 29 ++
 rtl/mod_sequencer.sv | 104 ++++++++++
 tb/tb_mod_sequencer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mod_sequencer_if.sv
// rtl/mod_sequencer_if.sv - request/result and ALU-borrow bundle for the modulo sequencer
interface mod_sequencer_if;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] remainder;
    logic [31:0] quotient;
    logic        div_by_zero;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [2:0]  alu_ctr;
    logic [31:0] alu_result;

    // Requester side: issues operations and supplies the combinational ALU result.
    modport master (
        output start, dividend, divisor, alu_result,
        input  busy, done, remainder, quotient, div_by_zero,
               alu_src1, alu_src2, alu_ctr
    );

    // Sequencer side.
    modport slave (
        input  start, dividend, divisor, alu_result,
        output busy, done, remainder, quotient, div_by_zero,
               alu_src1, alu_src2, alu_ctr
    );
endinterface

// File: rtl/mod_sequencer.sv
// rtl/mod_sequencer.sv - repeated-subtraction remainder engine that borrows the shared ALU
module mod_sequencer #(
    parameter logic [2:0] CTR_SLT  = 3'b100,
    parameter logic [2:0] CTR_SUB  = 3'b110,
    parameter logic [2:0] CTR_IDLE = 3'b000
) (
    input  logic          clk,
    input  logic          rst_n,
    mod_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_SUB  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] div_q, div_d;
    logic [31:0] quo_q, quo_d;
    logic        dbz_q, dbz_d;
    logic [31:0] alu_src1_d;
    logic [31:0] alu_src2_d;
    logic [2:0]  alu_ctr_d;

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rem_q   <= 32'd0;
            div_q   <= 32'd0;
            quo_q   <= 32'd0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            quo_q   <= quo_d;
            dbz_q   <= dbz_d;
        end
    end

    // Next-state and ALU drive; ALU outputs depend on registered state only.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        div_d      = div_q;
        quo_d      = quo_q;
        dbz_d      = dbz_q;
        alu_src1_d = 32'd0;
        alu_src2_d = 32'd0;
        alu_ctr_d  = CTR_IDLE;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    rem_d = bus.dividend;
                    quo_d = 32'd0;
                    if (bus.divisor == 32'd0) begin
                        // Zero divisor: finish immediately without touching the ALU.
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        div_d   = bus.divisor;
                        dbz_d   = 1'b0;
                        state_d = S_CMP;
                    end
                end
            end
            S_CMP: begin
                alu_src1_d = rem_q;
                alu_src2_d = div_q;
                alu_ctr_d  = CTR_SLT;
                state_d    = bus.alu_result[0] ? S_DONE : S_SUB;
            end
            S_SUB: begin
                alu_src1_d = rem_q;
                alu_src2_d = div_q;
                alu_ctr_d  = CTR_SUB;
                rem_d      = bus.alu_result;
                quo_d      = quo_q + 32'd1;
                state_d    = S_CMP;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy        = (state_q == S_CMP) || (state_q == S_SUB);
    assign bus.done        = (state_q == S_DONE);
    assign bus.remainder   = rem_q;
    assign bus.quotient    = quo_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.alu_src1    = alu_src1_d;
    assign bus.alu_src2    = alu_src2_d;
    assign bus.alu_ctr     = alu_ctr_d;

endmodule

// File: tb/tb_mod_sequencer.sv
// tb/tb_mod_sequencer.sv - self-checking bench for mod_sequencer
module tb_mod_sequencer;

    localparam logic [2:0] SLT  = 3'b100;
    localparam logic [2:0] SUB  = 3'b110;
    localparam logic [2:0] IDLE = 3'b000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mod_sequencer_if bus();

    mod_sequencer #(
        .CTR_SLT (SLT),
        .CTR_SUB (SUB),
        .CTR_IDLE(IDLE)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    // Shared combinational ALU stand-in.
    always_comb begin
        case (bus.alu_ctr)
            SLT:     bus.alu_result = {31'd0, (bus.alu_src1 < bus.alu_src2)};
            SUB:     bus.alu_result = bus.alu_src1 - bus.alu_src2;
            default: bus.alu_result = 32'd0;
        endcase
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: operation described by operands and cycle index since acceptance.
    bit          m_run = 1'b0;
    longint      m_k = 0;
    longint      m_d = 0;
    logic [31:0] m_a = '0, m_b = '0, m_q = '0;
    logic [31:0] m_rem = '0, m_quo = '0;
    logic        m_dbz = 1'b0;

    always @(negedge clk) begin : compare
        logic [31:0] idx, e_rem, e_quo, e_s1, e_s2;
        logic        e_busy, e_done, e_dbz;
        logic [2:0]  e_ctr;
        if (!rst_n) begin
            m_run = 1'b0;
            m_rem = '0;
            m_quo = '0;
            m_dbz = 1'b0;
        end
        if (m_run) begin
            idx    = 32'((m_k - 1) / 2);
            e_busy = (m_k < m_d);
            e_done = (m_k == m_d);
            e_rem  = m_a - m_b * idx;
            e_quo  = idx;
            e_dbz  = (m_b == 32'd0);
            e_s1   = e_busy ? e_rem : 32'd0;
            e_s2   = e_busy ? m_b : 32'd0;
            e_ctr  = e_busy ? ((m_k % 2 == 1) ? SLT : SUB) : IDLE;
        end else begin
            e_busy = 1'b0;
            e_done = 1'b0;
            e_rem  = m_rem;
            e_quo  = m_quo;
            e_dbz  = m_dbz;
            e_s1   = 32'd0;
            e_s2   = 32'd0;
            e_ctr  = IDLE;
        end
        chk("busy", 32'(bus.busy), 32'(e_busy));
        chk("done", 32'(bus.done), 32'(e_done));
        chk("remainder", bus.remainder, e_rem);
        chk("quotient", bus.quotient, e_quo);
        chk("div_by_zero", 32'(bus.div_by_zero), 32'(e_dbz));
        chk("alu_src1", bus.alu_src1, e_s1);
        chk("alu_src2", bus.alu_src2, e_s2);
        chk("alu_ctr", 32'(bus.alu_ctr), 32'(e_ctr));
        if (m_run) begin
            if (m_k == m_d) begin
                m_run = 1'b0;
                m_rem = e_rem;
                m_quo = e_quo;
                m_dbz = e_dbz;
            end else begin
                m_k++;
            end
        end else if (rst_n && bus.start) begin
            m_run = 1'b1;
            m_k   = 1;
            m_a   = bus.dividend;
            m_b   = bus.divisor;
            m_q   = (m_b == 32'd0) ? 32'd0 : m_a / m_b;
            m_d   = (m_b == 32'd0) ? 1 : 2 * longint'(m_q) + 2;
        end
    end

    // Runs one operation from an idle cycle; optional stray start at cycle junk_cycle.
    task automatic run_directed(input string name, input logic [31:0] a, input logic [31:0] b,
                                input int exp_cycle, input logic [31:0] exp_rem,
                                input logic [31:0] exp_quo, input logic exp_dbz,
                                input int junk_cycle,
                                output logic [23:0] hist, output logic saw_busy);
        int c;
        int done_at;
        done_at  = -1;
        hist     = '0;
        saw_busy = 1'b0;
        @(posedge clk); #1;
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        c = 0;
        for (int n = 0; n < 300; n++) begin
            @(posedge clk); #1;
            c++;
            bus.start    = (c == junk_cycle);
            bus.dividend = $urandom;
            bus.divisor  = $urandom;
            @(negedge clk);
            hist     = {hist[20:0], bus.alu_ctr};
            saw_busy = saw_busy | bus.busy;
            if (bus.done) begin
                done_at = c;
                break;
            end
        end
        bus.start = 1'b0;
        chk({name, "_done_cycle"}, 32'(done_at), 32'(exp_cycle));
        chk({name, "_remainder"}, bus.remainder, exp_rem);
        chk({name, "_quotient"}, bus.quotient, exp_quo);
        chk({name, "_div_by_zero"}, 32'(bus.div_by_zero), 32'(exp_dbz));
    endtask

    initial begin
        logic [23:0] hist;
        logic        saw_busy;
        int          ndone;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_remainder", bus.remainder, 32'd0);
        chk("rst_alu_ctr", 32'(bus.alu_ctr), 32'(IDLE));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        run_directed("m17_5", 32'd17, 32'd5, 8, 32'd2, 32'd3, 1'b0, -1, hist, saw_busy);
        chk("m17_5_ctr_seq", 32'(hist), 32'({SLT, SUB, SLT, SUB, SLT, SUB, SLT, IDLE}));
        run_directed("m4_9", 32'd4, 32'd9, 2, 32'd4, 32'd0, 1'b0, -1, hist, saw_busy);
        run_directed("m7_7", 32'd7, 32'd7, 4, 32'd0, 32'd1, 1'b0, -1, hist, saw_busy);
        run_directed("m0_3", 32'd0, 32'd3, 2, 32'd0, 32'd0, 1'b0, -1, hist, saw_busy);
        run_directed("m123_0", 32'd123, 32'd0, 1, 32'd123, 32'd0, 1'b1, -1, hist, saw_busy);
        chk("m123_0_busy", 32'(saw_busy), 32'd0);
        chk("m123_0_ctr", 32'(hist[2:0]), 32'(IDLE));
        run_directed("m100_7", 32'd100, 32'd7, 30, 32'd2, 32'd14, 1'b0, 3, hist, saw_busy);

        // Reset mid-operation: 50 mod 1, reset in cycle 5.
        @(posedge clk); #1;
        bus.start    = 1'b1;
        bus.dividend = 32'd50;
        bus.divisor  = 32'd1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_done", 32'(bus.done), 32'd0);
        chk("arst_remainder", bus.remainder, 32'd0);
        chk("arst_quotient", bus.quotient, 32'd0);
        chk("arst_div_by_zero", 32'(bus.div_by_zero), 32'd0);
        chk("arst_alu_src1", bus.alu_src1, 32'd0);
        chk("arst_alu_src2", bus.alu_src2, 32'd0);
        chk("arst_alu_ctr", 32'(bus.alu_ctr), 32'(IDLE));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        ndone = 0;
        repeat (120) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("arst_no_done", 32'(ndone), 32'd0);
        run_directed("post_rst_4_9", 32'd4, 32'd9, 2, 32'd4, 32'd0, 1'b0, -1, hist, saw_busy);

        // Randomized operations, back-to-back or with short gaps, with stray starts.
        for (int i = 0; i < 40; i++) begin
            int          mode;
            int          waited;
            logic [31:0] a, b;
            bit          seen;
            mode = $urandom_range(0, 9);
            if (mode < 5) begin
                b = $urandom_range(1, 50);
                a = b * $urandom_range(0, 20) + $urandom_range(0, 60);
            end else if (mode < 8) begin
                b = $urandom | 32'h1000_0000;
                a = $urandom;
            end else if (mode == 8) begin
                b = 32'd0;
                a = $urandom;
            end else begin
                b = $urandom_range(1, 1000);
                a = b;
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            bus.start    = 1'b1;
            bus.dividend = a;
            bus.divisor  = b;
            seen   = 1'b0;
            waited = 0;
            while (!seen && waited < 200) begin
                @(posedge clk); #1;
                bus.start    = ($urandom_range(0, 7) == 0);
                bus.dividend = $urandom;
                bus.divisor  = $urandom;
                @(negedge clk);
                waited++;
                if (bus.done) seen = 1'b1;
            end
            chk("rand_done_seen", 32'(seen), 32'd1);
            @(posedge clk); #1;
            bus.start = 1'b0;
            @(posedge clk); #1;
            if (m_run) begin
                // A stray start landed in the idle cycle; let that run finish too.
                for (int n = 0; n < 200 && m_run; n++) @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
